// File: rtl/ram_134_135_pkg.sv
// Shared widths and word/address types for the 8x4 scratch RAM.
package ram_134_135_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_134_135_if.sv
// Access bus for the scratch RAM: write data, strobes, shared address and read data.
interface ram_134_135_if;
    import ram_134_135_pkg::*;

    word_t data_in;
    logic  wr;
    logic  rd;
    addr_t add;
    word_t data_out;

    modport master (
        output data_in,
        output wr,
        output rd,
        output add,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  wr,
        input  rd,
        input  add,
        output data_out
    );

endinterface

// File: rtl/ram_134_135.sv
// 8x4 single-port RAM with registered, write-through reads; contents cleared by async reset.
module ram_134_135
    import ram_134_135_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DEPTH_P  = DEPTH
) (
    input logic           clk,
    input logic           rst_n,
    ram_134_135_if.slave  bus
);

    if (DEPTH_P != (1 << ADDR_W_P) || DATA_W_P != DATA_W || ADDR_W_P != ADDR_W) begin : gParamCheck
        $error("ram_134_135: DEPTH must equal 2**ADDR_W and widths must match the package");
    end

    word_t mem_q [DEPTH];
    word_t readData_q;
    word_t readData_d;

    // A simultaneous write forwards the incoming word so a stale value is never returned.
    always_comb begin
        readData_d = readData_q;
        if (bus.rd) begin
            if (bus.wr) begin
                readData_d = bus.data_in;
            end else begin
                readData_d = mem_q[bus.add];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.wr) begin
            mem_q[bus.add] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData_q <= '0;
        end else begin
            readData_q <= readData_d;
        end
    end

    assign bus.data_out = readData_q;

endmodule

// File: tb/tb_ram_134_135.sv
// Self-checking bench for ram_134_135: directed vector table, hand sequences, random vs. model.
module tb_ram_134_135;
    import ram_134_135_pkg::*;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [2:0] add;
        logic [3:0] din;
        logic [3:0] expOut;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   failCount;
    vec_t vecs[$];
    logic [3:0] model [8];
    logic [3:0] modelOut;

    ram_134_135_if bus ();

    ram_134_135 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    function automatic void addVec(input logic w, input logic r, input logic [2:0] a,
                                   input logic [3:0] d, input logic [3:0] e, input string n);
        vec_t v;
        v.wr = w; v.rd = r; v.add = a; v.din = d; v.expOut = e; v.name = n;
        vecs.push_back(v);
    endfunction

    // Drive inputs just after an edge, then advance to 1 ns past the next rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [2:0] a, input logic [3:0] d);
        bus.wr      = w;
        bus.rd      = r;
        bus.add     = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expected);
        checkCount++;
        if (bus.data_out !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: data_out=%h expected=%h at %0t", name, bus.data_out, expected, $time);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.add = '0; bus.data_in = '0;
        rst_n = 1'b0;

        for (int i = 0; i < 8; i++) addVec(1'b0, 1'b1, 3'(i), 4'h0, 4'h0, "resetRead");
        for (int i = 0; i < 4; i++) addVec(1'b1, 1'b0, 3'(i), 4'(i), 4'h0, "writeLow");
        for (int i = 0; i < 4; i++) addVec(1'b0, 1'b1, 3'(i), 4'h0, 4'(i), "readBack");
        addVec(1'b0, 1'b0, 3'd0, 4'h0, 4'h3, "hold");
        addVec(1'b1, 1'b1, 3'd5, 4'hA, 4'hA, "writeThrough");
        addVec(1'b0, 1'b1, 3'd5, 4'h0, 4'hA, "readAfterWT");
        for (int i = 0; i < 8; i++) addVec(1'b1, 1'b0, 3'(i), 4'(15 - i), 4'hA, "fillHold");
        addVec(1'b1, 1'b0, 3'd7, 4'h6, 4'hA, "overwrite");
        for (int i = 0; i < 8; i++) addVec(1'b0, 1'b1, 3'(i), 4'h0, (i == 7) ? 4'h6 : 4'(15 - i), "fullRead");

        #5;
        checkOutput("inReset", 4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].wr, vecs[k].rd, vecs[k].add, vecs[k].din);
            checkOutput(vecs[k].name, vecs[k].expOut);
        end

        // Unknown strobes must leave both the array and the output register alone.
        applyStimulus(1'bx, 1'bx, 3'd3, 4'h5);
        checkOutput("xStrobeHold", 4'h6);
        applyStimulus(1'b0, 1'b1, 3'd3, 4'h0);
        checkOutput("xStrobeNoWrite", 4'hC);

        #10;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetOut", 4'h0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 3'(i), 4'h0);
            checkOutput("postResetRead", 4'h0);
        end

        for (int i = 0; i < 8; i++) model[i] = 4'h0;
        modelOut = 4'h0;
        for (int n = 0; n < 400; n++) begin
            logic       w;
            logic       r;
            logic [2:0] a;
            logic [3:0] d;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            d = 4'($urandom_range(0, 15));
            if (r) modelOut = w ? d : model[a];
            if (w) model[a] = d;
            applyStimulus(w, r, a, d);
            checkOutput("random", modelOut);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
